store_buffer: RTL and testbench

- FIFO of committed stores between the MEM-stage address/byte-enable logic and the data memory.
- Accepts one store per cycle from MEM and drains the oldest store into the data memory one per cycle when allowed.
- Decouples store commit from the memory write port.
- Merges pending buffered bytes over the memory's combinational read data, so loads always see the youngest value.

---
 rtl/store_buffer_pkg.sv | 22 ++
 rtl/store_buffer_merge.sv | 66 ++++++
 rtl/store_buffer.sv | 111 +++++++++++
 tb/tb_store_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared definitions for the committed-store buffer and its load-merge logic.
//   SB_DEPTH   : default number of buffered stores
//   LANES      : byte lanes per 32-bit word
//   LANE_W     : bits per byte lane
//   sb_entry_t : one buffered store {word address, byte enables, data, pc}
// -----------------------------------------------------------------------------
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int LANES    = 4;
  localparam int LANE_W   = 8;

  typedef struct packed {
    logic [29:0] addr_w;  // word address (byte address bits [31:2])
    logic [3:0]  be;      // bit i enables byte lane i
    logic [31:0] wdata;   // lane-aligned store data
    logic [31:0] pc;      // pc of the store, for the memory write log
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_merge.sv
// -----------------------------------------------------------------------------
// sb_merge
// Purely combinational load-forwarding merge. For every byte lane the valid
// entries are scanned oldest to youngest; the youngest entry whose word
// address matches the load and whose byte enable is set supplies that lane,
// otherwise the lane comes from the memory read data.
// Ports:
//   entries_i  : entry storage array
//   rd_ptr_i   : index of the oldest entry
//   count_i    : number of valid entries
//   ld_addr_i  : load byte address
//   dm_rdata_i : combinational memory read data for ld_addr_i
//   ld_data_o  : merged load data
//   ld_hit_o   : at least one lane was supplied by the buffer
// -----------------------------------------------------------------------------
module sb_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  sb_entry_t        entries_i [DEPTH],
  input  logic [PTR_W-1:0] rd_ptr_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [31:0]      ld_addr_i,
  input  logic [31:0]      dm_rdata_i,
  output logic [31:0]      ld_data_o,
  output logic             ld_hit_o
);

  logic [LANES-1:0] lane_hit;

  // Byte offset does not select lanes; the whole word is merged.
  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr_i[1:0];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] lane_data;
    logic              lane_src_buf;
    logic [PTR_W-1:0]  idx;

    always_comb begin
      lane_data    = dm_rdata_i[gi*LANE_W +: LANE_W];
      lane_src_buf = 1'b0;
      idx          = '0;
      // Walking oldest to youngest lets later matches overwrite earlier ones,
      // so the youngest matching store wins.
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_i + PTR_W'(i);
        if ((CNT_W'(i) < count_i) &&
            (entries_i[idx].addr_w == ld_addr_i[31:2]) &&
            entries_i[idx].be[gi]) begin
          lane_data    = entries_i[idx].wdata[gi*LANE_W +: LANE_W];
          lane_src_buf = 1'b1;
        end
      end
    end

    assign ld_data_o[gi*LANE_W +: LANE_W] = lane_data;
    assign lane_hit[gi]                   = lane_src_buf;
  end

  assign ld_hit_o = |lane_hit;

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// FIFO of committed stores between the MEM stage and the data memory. Accepts
// one store per cycle, drains the oldest store per cycle when the memory write
// port is free, and forwards buffered bytes to loads.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   st_valid/st_ready      : store push handshake (ready = count < DEPTH)
//   st_addr/st_be/st_wdata/st_pc : store payload
//   drain_en               : memory write port free this cycle
//   dm_we/dm_addr/dm_be/dm_wdata/dm_pc : oldest entry toward the data memory
//   ld_addr/dm_rdata       : load address and raw memory read data
//   ld_data/ld_hit         : merged load data and buffer-hit flag
//   empty                  : no stores pending
// -----------------------------------------------------------------------------
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_wdata,
  input  logic [31:0] st_pc,
  input  logic        drain_en,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] ld_addr,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ld_data,
  output logic        ld_hit,
  output logic        empty
);

  sb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  sb_entry_t        head;

  // Byte offset is dropped on store; the entry holds a word address.
  logic unused_st_lo;
  assign unused_st_lo = ^st_addr[1:0];

  // Ready depends only on registered count: a full buffer never accepts a
  // push in the same cycle it pops.
  assign st_ready = (count_q < CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = st_valid && st_ready;
  assign pop      = drain_en && !empty;
  assign dm_we    = pop;

  assign head     = entries_q[rd_ptr_q];
  assign dm_addr  = {head.addr_w, 2'b00};
  assign dm_be    = head.be;
  assign dm_wdata = head.wdata;
  assign dm_pc    = head.pc;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        entries_q[wr_ptr_q] <= '{addr_w: st_addr[31:2], be: st_be,
                                 wdata: st_wdata, pc: st_pc};
      end
    end
  end

  // The entry being popped still participates (its write lands at the edge);
  // a store pushed this cycle is not yet in count_q and so does not.
  sb_merge #(.DEPTH(DEPTH)) u_merge (
    .entries_i  (entries_q),
    .rd_ptr_i   (rd_ptr_q),
    .count_i    (count_q),
    .ld_addr_i  (ld_addr),
    .dm_rdata_i (dm_rdata),
    .ld_data_o  (ld_data),
    .ld_hit_o   (ld_hit)
  );

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed self-checking bench for store_buffer.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] st_pc;
  logic        drain_en;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic [31:0] ld_addr;
  logic [31:0] dm_rdata;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;
  logic allow_drop = 1'b0;

  store_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .st_pc    (st_pc),
    .drain_en (drain_en),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_be    (dm_be),
    .dm_wdata (dm_wdata),
    .dm_pc    (dm_pc),
    .ld_addr  (ld_addr),
    .dm_rdata (dm_rdata),
    .ld_data  (ld_data),
    .ld_hit   (ld_hit),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // The MEM stage must stall on !st_ready; only the deliberate overflow test
  // is allowed to present a store to a full buffer.
  always @(posedge clk) begin
    if (reset && st_valid && !st_ready && !allow_drop)
      $error("store presented while st_ready=0");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("  ok %s = %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, input logic [31:0] pc);
    st_valid = v;
    st_addr  = a;
    st_be    = be;
    st_wdata = d;
    st_pc    = pc;
  endtask

  initial begin
    reset    = 1'b0;
    drain_en = 1'b1;
    ld_addr  = 32'h0;
    dm_rdata = 32'hCAFE_F00D;
    set_store(1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    #3;
    // ---- reset state
    chk("rst_empty",   32'(empty),    32'd1);
    chk("rst_ready",   32'(st_ready), 32'd1);
    chk("rst_dm_we",   32'(dm_we),    32'd0);
    chk("rst_ld_hit",  32'(ld_hit),   32'd0);
    chk("rst_ld_data", ld_data,       32'hCAFE_F00D);
    chk("rst_dm_addr", dm_addr,       32'h0);
    chk("rst_dm_pc",   dm_pc,         32'h0);
    tick();
    reset = 1'b1;
    tick();

    // ---- single store, drain on
    set_store(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h3000);
    #1;
    chk("t1_no_pop_when_empty", 32'(dm_we), 32'd0);
    tick();
    st_valid = 1'b0;
    chk("t1_dm_we",    32'(dm_we), 32'd1);
    chk("t1_dm_addr",  dm_addr,    32'h10);
    chk("t1_dm_be",    32'(dm_be), 32'hF);
    chk("t1_dm_wdata", dm_wdata,   32'hDEAD_BEEF);
    chk("t1_dm_pc",    dm_pc,      32'h3000);
    tick();
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_dm_we_after", 32'(dm_we), 32'd0);

    // ---- fill and full
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'(4 * i), 4'hF, 32'h1000 + 32'(i), 32'h100 + 32'(i));
      tick();
    end
    st_valid = 1'b0;
    #1;
    chk("t2_full_ready", 32'(st_ready), 32'd0);
    chk("t2_not_empty",  32'(empty),    32'd0);
    allow_drop = 1'b1;
    set_store(1'b1, 32'h50, 4'hF, 32'h0000_0BAD, 32'h999);
    tick();
    st_valid   = 1'b0;
    allow_drop = 1'b0;
    drain_en   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_we_%0d", i),    32'(dm_we), 32'd1);
      chk($sformatf("t2_addr_%0d", i),  dm_addr,    32'(4 * i));
      chk($sformatf("t2_wdata_%0d", i), dm_wdata,   32'h1000 + 32'(i));
      tick();
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // ---- byte merge, youngest wins
    drain_en = 1'b0;
    set_store(1'b1, 32'h20, 4'b0011, 32'h0000_1122, 32'h200);
    tick();
    set_store(1'b1, 32'h20, 4'b0001, 32'h0000_00AA, 32'h204);
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h20;
    dm_rdata = 32'h5566_7788;
    #1;
    chk("t3_ld_data", ld_data,       32'h5566_11AA);
    chk("t3_ld_hit",  32'(ld_hit),   32'd1);
    ld_addr = 32'h22;
    #1;
    chk("t3_ld_data_offs", ld_data, 32'h5566_11AA);
    drain_en = 1'b1;
    #1;
    chk("t3_popping_still_merges", ld_data, 32'h5566_11AA);
    tick();
    chk("t3_after_pop1", ld_data, 32'h5566_77AA);
    tick();
    chk("t3_after_pop2", ld_data, 32'h5566_7788);
    chk("t3_hit_empty",  32'(ld_hit), 32'd0);

    // ---- simultaneous push and pop at count 2, across the wrap
    drain_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_store(1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'h2000 + 32'(k), 32'h400);
      tick();
    end
    drain_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_store(1'b1, 32'h100 + 32'(4 * (k + 2)), 4'hF, 32'h2000 + 32'(k + 2), 32'h400);
      #1;
      chk($sformatf("t4_pp_data_%0d", k), dm_wdata, 32'h2000 + 32'(k));
      chk($sformatf("t4_pp_addr_%0d", k), dm_addr,  32'h100 + 32'(4 * k));
      tick();
      chk($sformatf("t4_count_%0d", k), 32'(dut.count_q), 32'd2);
    end
    st_valid = 1'b0;
    for (int k = 4; k < 6; k++) begin
      #1;
      chk($sformatf("t4_tail_data_%0d", k), dm_wdata, 32'h2000 + 32'(k));
      tick();
    end
    chk("t4_empty", 32'(empty), 32'd1);

    // ---- reset mid-operation
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_store(1'b1, 32'h200 + 32'(4 * k), 4'hF, 32'h3000 + 32'(k), 32'h500);
      tick();
    end
    st_valid = 1'b0;
    ld_addr  = 32'h200;
    drain_en = 1'b1;
    #1;
    chk("t5_pre_hit", 32'(ld_hit), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_dm_we",   32'(dm_we),    32'd0);
    chk("t5_empty",   32'(empty),    32'd1);
    chk("t5_ready",   32'(st_ready), 32'd1);
    chk("t5_ld_hit",  32'(ld_hit),   32'd0);
    chk("t5_dm_addr", dm_addr,       32'h0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_no_stale_we_%0d", k), 32'(dm_we), 32'd0);
    end

    // ---- miss
    drain_en = 1'b0;
    set_store(1'b1, 32'h40, 4'hF, 32'h0000_0099, 32'h600);
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h44;
    dm_rdata = 32'h1234_5678;
    #1;
    chk("t6_miss_data", ld_data,     32'h1234_5678);
    chk("t6_miss_hit",  32'(ld_hit), 32'd0);
    ld_addr = 32'h40;
    #1;
    chk("t6_hit_data", ld_data,     32'h0000_0099);
    chk("t6_hit_hit",  32'(ld_hit), 32'd1);
    drain_en = 1'b1;
    tick();
    chk("t6_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
